// File: rtl/video_timing_gen_if.sv
// Raster timing bundle: advance enable from the sink side, timing and
// coordinate outputs from the generator side.
interface video_timing_gen_if #(
  parameter int unsigned CNT_W = 11
);
  logic             en_i;
  logic             de_o;
  logic             hs_o;
  logic             vs_o;
  logic [CNT_W-1:0] x_o;
  logic [CNT_W-1:0] y_o;
  logic             sof_o;
  logic             eol_o;
  logic             pix_o;

  // Generator side
  modport master (
    input  en_i,
    output de_o, hs_o, vs_o, x_o, y_o, sof_o, eol_o, pix_o
  );

  // Consumer side (encoders / bench)
  modport slave (
    output en_i,
    input  de_o, hs_o, vs_o, x_o, y_o, sof_o, eol_o, pix_o
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counter pair plus registered de/hsync/vsync,
// coordinates, frame/line pulses and a 1-bit checkerboard pixel. All outputs
// are decoded from the current counters and registered, so they trail the
// counters by one enabled cycle.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = 11
) (
  input  logic                clk_i,
  input  logic                rst_i,
  video_timing_gen_if.master  vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;

  logic             de_q,  de_d;
  logic             hs_q,  hs_d;
  logic             vs_q,  vs_d;
  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_q;
  logic             sof_q, sof_d;
  logic             eol_q, eol_d;
  logic             pix_q, pix_d;

  logic hs_act;
  logic vs_act;

  // Counter advance: h wraps at end of line, v steps on each h wrap and
  // wraps at end of frame.
  always_comb begin
    h_d = h_q + ONE;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d = '0;
      end else begin
        v_d = v_q + ONE;
      end
    end
  end

  // Output decode from the current counter position. vsync depends on v only,
  // so it can change level only where v changes, i.e. at line start.
  always_comb begin
    de_d   = (h_q < H_ACT) && (v_q < V_ACT);
    hs_act = (h_q >= HS_START) && (h_q < HS_END);
    vs_act = (v_q >= VS_START) && (v_q < VS_END);
    hs_d   = HS_POL ? hs_act : ~hs_act;
    vs_d   = VS_POL ? vs_act : ~vs_act;
    sof_d  = (h_q == '0) && (v_q == '0);
    eol_d  = (h_q == H_LAST);
    pix_d  = de_d & (h_q[4] ^ v_q[4]);
  end

  // Counters and registered outputs; en_i low freezes everything, reset wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q   <= '0;
      v_q   <= '0;
      de_q  <= 1'b0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      x_q   <= '0;
      y_q   <= '0;
      sof_q <= 1'b0;
      eol_q <= 1'b0;
      pix_q <= 1'b0;
    end else if (vid.en_i) begin
      h_q   <= h_d;
      v_q   <= v_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      x_q   <= h_q;
      y_q   <= v_q;
      sof_q <= sof_d;
      eol_q <= eol_d;
      pix_q <= pix_d;
    end
  end

  assign vid.de_o  = de_q;
  assign vid.hs_o  = hs_q;
  assign vid.vs_o  = vs_q;
  assign vid.x_o   = x_q;
  assign vid.y_o   = y_q;
  assign vid.sof_o = sof_q;
  assign vid.eol_o = eol_q;
  assign vid.pix_o = pix_q;

endmodule
